// File: rtl/keypad_scanner.sv
// 4x4 active-low key matrix scanner with frame-level debounce.
// Emits a held key code, a valid level, a one-cycle press pulse and a multi-key flag.
module keypad_scanner #(
   parameter int unsigned SCAN_DIV = 4,
   parameter int unsigned DEBOUNCE = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row_in,
   output logic [3:0] col_out,
   output logic [3:0] keypad_code,
   output logic       key_valid,
   output logic       key_press,
   output logic       multi_key
);

   localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned CntW = $clog2(DEBOUNCE + 1);
   localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE);

   typedef enum logic [1:0] {KindNone, KindOne, KindMulti} kind_e;

   logic [3:0]      sync1_q, sync2_q;
   logic [DivW-1:0] div_q, div_d;
   logic [1:0]      col_q, col_d;
   kind_e           acc_kind_q, acc_kind_d;
   logic [3:0]      acc_code_q, acc_code_d;
   kind_e           cand_kind_q, cand_kind_d;
   logic [3:0]      cand_code_q, cand_code_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   kind_e           deb_kind_q, deb_kind_d;
   logic [3:0]      code_q, code_d;
   logic            press_q, press_d;

   logic       sample, frame_end, lows_single, same;
   logic [3:0] lows;
   logic [1:0] row_idx;
   kind_e      res_kind;
   logic [3:0] res_code;

   assign sample    = (div_q == DivLast);
   assign frame_end = sample && (col_q == 2'd3);
   assign lows      = ~sync2_q;

   always_comb begin
      div_d = sample ? '0 : div_q + 1'b1;
      col_d = sample ? col_q + 2'd1 : col_q;
   end

   // Frame accumulator; the result includes the column-3 sample taken this cycle.
   always_comb begin
      row_idx = '0;
      for (int r = 0; r < 4; r++) begin
         if (lows[r]) row_idx = 2'(r);
      end
      lows_single = (lows != 4'd0) && ((lows & 4'(lows - 4'd1)) == 4'd0);
      acc_kind_d  = acc_kind_q;
      acc_code_d  = acc_code_q;
      if (sample && (lows != 4'd0)) begin
         if ((acc_kind_q == KindNone) && lows_single) begin
            acc_kind_d = KindOne;
            acc_code_d = {row_idx, col_q};
         end else begin
            acc_kind_d = KindMulti;
         end
      end
      res_kind = acc_kind_d;
      res_code = acc_code_d;
      if (frame_end) begin
         acc_kind_d = KindNone;
         acc_code_d = '0;
      end
   end

   // Debounce: candidate plus run length, committed once the run reaches DEBOUNCE.
   always_comb begin
      cand_kind_d = cand_kind_q;
      cand_code_d = cand_code_q;
      cnt_d       = cnt_q;
      deb_kind_d  = deb_kind_q;
      code_d      = code_q;
      press_d     = 1'b0;
      same        = (res_kind == cand_kind_q) &&
                    ((res_kind != KindOne) || (res_code == cand_code_q));
      if (frame_end) begin
         if (same) begin
            if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
         end else begin
            cand_kind_d = res_kind;
            cand_code_d = res_code;
            cnt_d       = CntW'(1);
         end
         if (cnt_d == CntMax) begin
            deb_kind_d = cand_kind_d;
            if (cand_kind_d == KindOne) begin
               code_d  = cand_code_d;
               press_d = !((deb_kind_q == KindOne) && (code_q == cand_code_d));
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q     <= 4'b1111;
         sync2_q     <= 4'b1111;
         div_q       <= '0;
         col_q       <= '0;
         acc_kind_q  <= KindNone;
         acc_code_q  <= '0;
         cand_kind_q <= KindNone;
         cand_code_q <= '0;
         cnt_q       <= '0;
         deb_kind_q  <= KindNone;
         code_q      <= '0;
         press_q     <= 1'b0;
      end else begin
         sync1_q     <= row_in;
         sync2_q     <= sync1_q;
         div_q       <= div_d;
         col_q       <= col_d;
         acc_kind_q  <= acc_kind_d;
         acc_code_q  <= acc_code_d;
         cand_kind_q <= cand_kind_d;
         cand_code_q <= cand_code_d;
         cnt_q       <= cnt_d;
         deb_kind_q  <= deb_kind_d;
         code_q      <= code_d;
         press_q     <= press_d;
      end
   end

   assign col_out     = ~(4'b0001 << col_q);
   assign keypad_code = code_q;
   assign key_valid   = (deb_kind_q == KindOne);
   assign multi_key   = (deb_kind_q == KindMulti);
   assign key_press   = press_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Frame-aligned bench for keypad_scanner: a key-matrix model drives the rows and a
// scoreboard of hand-derived per-frame outputs is checked at each frame end.
module tb_keypad_scanner;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  row_in;
   logic [3:0]  col_out;
   logic [3:0]  keypad_code;
   logic        key_valid;
   logic        key_press;
   logic        multi_key;
   logic [15:0] keys;

   localparam logic [15:0] K1 = 16'h0200;  // code 1001
   localparam logic [15:0] K2 = 16'h0080;  // code 0111
   localparam logic [15:0] KM = K1 | K2;

   typedef struct packed {
      logic [3:0] code;
      logic       valid;
      logic       press;
      logic       multi;
   } out_t;

   typedef struct {
      logic [15:0] keys;
      out_t        exp;
   } vec_t;

   vec_t main_tab[$];
   vec_t post_tab[$];
   out_t sb_q[$];
   logic [3:0] col_exp [4];
   int errors = 0;
   int checks = 0;

   keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .row_in     (row_in),
      .col_out    (col_out),
      .keypad_code(keypad_code),
      .key_valid  (key_valid),
      .key_press  (key_press),
      .multi_key  (multi_key)
   );

   always #5 clk = ~clk;

   // Pressed key {r,c} pulls row r low while column c is driven low.
   always_comb begin
      row_in = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (keys[r*4+c] && (col_out[c] == 1'b0)) row_in[r] = 1'b0;
         end
      end
   end

   function automatic vec_t mk(input logic [15:0] k, input logic [3:0] code,
                               input logic v, input logic p, input logic m);
      vec_t x;
      x.keys      = k;
      x.exp.code  = code;
      x.exp.valid = v;
      x.exp.press = p;
      x.exp.multi = m;
      return x;
   endfunction

   function automatic out_t dut_out();
      out_t o;
      o.code  = keypad_code;
      o.valid = key_valid;
      o.press = key_press;
      o.multi = multi_key;
      return o;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive one frame of keys, starting at column 0 / div 0, and check at the frame end.
   task automatic run_frame(input string tag, input int idx, input vec_t v);
      int   pulses;
      out_t want;
      pulses = 0;
      keys   = v.keys;
      sb_q.push_back(v.exp);
      for (int t = 1; t <= 16; t++) begin
         tick();
         if (key_press === 1'b1) pulses++;
         if ((t % 4 == 0) || (t % 4 == 3))
            check($sformatf("%s %0d col_out t=%0d", tag, idx, t), 32'(col_out),
                  32'(col_exp[(t/4)%4]));
      end
      if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s %0d scoreboard empty", tag, idx);
      end else begin
         want = sb_q.pop_front();
         check($sformatf("%s %0d outputs {code,valid,press,multi}", tag, idx),
               32'(dut_out()), 32'(want));
         check($sformatf("%s %0d press pulse count", tag, idx), 32'(pulses),
               32'(want.press));
      end
   endtask

   initial begin
      col_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

      // single press, 6 frames held, then release
      main_tab.push_back(mk(K1,    4'h0, 1'b0, 1'b0, 1'b0));
      main_tab.push_back(mk(K1,    4'h0, 1'b0, 1'b0, 1'b0));
      main_tab.push_back(mk(K1,    4'h9, 1'b1, 1'b1, 1'b0));
      main_tab.push_back(mk(K1,    4'h9, 1'b1, 1'b0, 1'b0));
      main_tab.push_back(mk(K1,    4'h9, 1'b1, 1'b0, 1'b0));
      main_tab.push_back(mk(K1,    4'h9, 1'b1, 1'b0, 1'b0));
      main_tab.push_back(mk(16'h0, 4'h9, 1'b1, 1'b0, 1'b0));
      main_tab.push_back(mk(16'h0, 4'h9, 1'b1, 1'b0, 1'b0));
      main_tab.push_back(mk(16'h0, 4'h9, 1'b0, 1'b0, 1'b0));
      // bounce
      main_tab.push_back(mk(K1,    4'h9, 1'b0, 1'b0, 1'b0));
      main_tab.push_back(mk(16'h0, 4'h9, 1'b0, 1'b0, 1'b0));
      main_tab.push_back(mk(K1,    4'h9, 1'b0, 1'b0, 1'b0));
      main_tab.push_back(mk(16'h0, 4'h9, 1'b0, 1'b0, 1'b0));
      // multi-key, then resolve to 0111
      main_tab.push_back(mk(KM,    4'h9, 1'b0, 1'b0, 1'b0));
      main_tab.push_back(mk(KM,    4'h9, 1'b0, 1'b0, 1'b0));
      main_tab.push_back(mk(KM,    4'h9, 1'b0, 1'b0, 1'b1));
      main_tab.push_back(mk(KM,    4'h9, 1'b0, 1'b0, 1'b1));
      main_tab.push_back(mk(K2,    4'h9, 1'b0, 1'b0, 1'b1));
      main_tab.push_back(mk(K2,    4'h9, 1'b0, 1'b0, 1'b1));
      main_tab.push_back(mk(K2,    4'h7, 1'b1, 1'b1, 1'b0));
      // direct swaps with no gap
      main_tab.push_back(mk(K1,    4'h7, 1'b1, 1'b0, 1'b0));
      main_tab.push_back(mk(K1,    4'h7, 1'b1, 1'b0, 1'b0));
      main_tab.push_back(mk(K1,    4'h9, 1'b1, 1'b1, 1'b0));
      main_tab.push_back(mk(K2,    4'h9, 1'b1, 1'b0, 1'b0));
      main_tab.push_back(mk(K2,    4'h9, 1'b1, 1'b0, 1'b0));
      main_tab.push_back(mk(K2,    4'h7, 1'b1, 1'b1, 1'b0));
      // accept 1001 ahead of the mid-hold reset
      main_tab.push_back(mk(K1,    4'h7, 1'b1, 1'b0, 1'b0));
      main_tab.push_back(mk(K1,    4'h7, 1'b1, 1'b0, 1'b0));
      main_tab.push_back(mk(K1,    4'h9, 1'b1, 1'b1, 1'b0));
      // after reset, key still held
      post_tab.push_back(mk(K1,    4'h0, 1'b0, 1'b0, 1'b0));
      post_tab.push_back(mk(K1,    4'h0, 1'b0, 1'b0, 1'b0));
      post_tab.push_back(mk(K1,    4'h9, 1'b1, 1'b1, 1'b0));

      keys = 16'h0;
      rst  = 1'b1;
      repeat (3) tick();
      check("reset outputs during rst", 32'(dut_out()), 32'(7'b0));
      rst = 1'b0;
      check("reset outputs after release", 32'(dut_out()), 32'(7'b0));
      check("reset col_out", 32'(col_out), 32'(4'b1110));

      for (int i = 0; i < main_tab.size(); i++) run_frame("main", i, main_tab[i]);

      // reset pulse mid-frame while 1001 is accepted and held
      repeat (5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid-hold reset outputs", 32'(dut_out()), 32'(7'b0));
      check("mid-hold reset col_out", 32'(col_out), 32'(4'b1110));

      for (int i = 0; i < post_tab.size(); i++) run_frame("post", i, post_tab[i]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 active-low key matrix and debounces it. Produces a stable 4-bit key code with a valid level and a one-cycle press pulse. Sits directly upstream of the `who_push` first-press arbiter, whose `keypad_in` is fed from `keypad_code`, qualified by `key_valid` and `key_press`. Player keys are 4'b1001 (row 2, col 1) and 4'b0111 (row 1, col 3).

## Interface
- `SCAN_DIV`, 4: clock cycles each column is driven; must be ≥ 4.
- `DEBOUNCE`, 3: consecutive identical scan frames required to accept a new state; must be ≥ 1.

- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `row_in`  in  4  matrix rows, active-low (pulled up externally), asynchronous
- `col_out`  out  4  column drive, active-low one-hot
- `keypad_code`  out  4  debounced code {row[1:0], col[1:0]}; holds last accepted code
- `key_valid`  out  1  high while exactly one key is debounced-held
- `key_press`  out  1  one-cycle pulse on each newly accepted single key
- `multi_key`  out  1  high while the debounced state is "more than one key"

## Operation
- `row_in` passes through a 2-FF synchronizer. All decisions use the synchronized value.
- The dwell counter `div` counts 0..SCAN_DIV-1. At terminal count, the column index `col` advances 0→1→2→3→0 (wrap).
- `col_out` = ~(4'b0001 << col).
- **Sampling:** at `div == SCAN_DIV-1`, sample the synchronized rows for the current column. A low bit r means key {r, col} is pressed.
- **Frame accumulator:** spans columns 0..3. The frame result is:
  - NONE if no lows were seen.
  - ONE(code) if exactly one low was seen across the whole frame.
  - MULTI if more than one low was seen, whether in one row sample or across columns.
- The accumulator clears after the column-3 sample.
- **Debounce FSM:** state = (candidate, `stable_cnt`). At each frame end:
  - If the result equals the candidate, `stable_cnt` increments, saturating at DEBOUNCE.
  - Otherwise, candidate ← result and `stable_cnt` ← 1.
  - When `stable_cnt` becomes DEBOUNCE, debounced state ← candidate.
- **Outputs** follow the debounced state:
  - NONE: `key_valid` = 0, `multi_key` = 0, `keypad_code` holds.
  - ONE(c): `key_valid` = 1, `multi_key` = 0, `keypad_code` = c.
  - MULTI: `key_valid` = 0, `multi_key` = 1, `keypad_code` holds.
- **`key_press`** pulses when the debounced state changes to ONE(c) from any state other than ONE(c). This includes NONE→ONE, MULTI→ONE, and ONE(a)→ONE(b). It never pulses twice for one continuous hold.
- **Reset** (any cycle, including mid-scan or mid-hold):
  - `div` = 0, `col` = 0, synchronizer = 4'b1111, accumulator cleared.
  - candidate = NONE, `stable_cnt` = 0, debounced = NONE.
  - There is no `key_press` in the reset cycle or the cycle after.

## Timing
- Reset values: `col_out` = 4'b1110, `keypad_code` = 4'b0000, `key_valid` = 0, `key_press` = 0, `multi_key` = 0.
- One frame = 4·SCAN_DIV cycles. The column changes on the cycle after the terminal `div`.
- The synchronizer adds 2 cycles. Row changes must precede the sample point by ≥ 2 cycles to count in that column, which is guaranteed for a stable key when SCAN_DIV ≥ 4.
- All outputs are registered and update on the cycle after the frame-end sample that completes DEBOUNCE.
- Press latency: from the first frame fully containing the press, `key_press` fires 1 cycle after the end of the DEBOUNCE-th consecutive frame.
- Release latency is symmetric: `key_valid` falls after DEBOUNCE consecutive NONE frames.
- A key that changes inside a frame yields a mixed result. It is accepted only once DEBOUNCE clean frames follow.

## Test plan
Settings: SCAN_DIV = 4, DEBOUNCE = 3, frame = 16 cycles. The bench matrix model drives `row_in[r]` low while `col_out[c]` = 0 for each pressed {r, c}.
- **Reset and scan:** `rst` high for 3 cycles, then low → all outputs at reset values. `col_out` then steps 1110, 1101, 1011, 0111, 1110 every 4 cycles.
- **Single press, key 1001 held 6 frames:**
  - Exactly one `key_press` pulse, at the cycle after the 3rd full frame's column-3 sample.
  - `keypad_code` = 4'b1001 and `key_valid` = 1 from that cycle.
  - After release, `key_valid` falls 3 frames later and `keypad_code` stays 1001.
- **Bounce, key 1001 present/absent/present/absent for 1 frame each:** no `key_press`, `key_valid` stays 0.
- **Multi-key then resolve:**
  - Keys 1001 and 0111 held together 4 frames → `multi_key` = 1, `key_valid` = 0, no pulse.
  - Release 1001 while keeping 0111 → after 3 frames, `multi_key` = 0, one `key_press` pulse, `keypad_code` = 0111.
- **Direct swap:** hold 1001 until accepted, then switch to 0111 with no gap → second `key_press` with `keypad_code` = 0111. `key_valid` stays 1 throughout.
- **Reset mid-hold:** `rst` pulses 1 cycle while 1001 is accepted and still held → next cycle all outputs = reset values. A fresh `key_press` (code 1001) follows 3 full frames after `rst` deasserts.
